fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001: Parameter PC_WIDTH, default 32, SHALL set the width in bits of the PC and all PC-derived values.
REQ-002: Parameter IMEM_DEPTH, default 64, SHALL set the number of 32-bit instruction words (power of two, >=2); IDX = log2(IMEM_DEPTH).
REQ-003: Parameter RESET_PC, default 0, SHALL be the PC loaded on reset; it must be word-aligned.
REQ-004: clk  in  1  sole clock; all state updates on the rising edge.
REQ-005: reset  in  1  synchronous, active-high reset.
REQ-006: pc_src  in  1  decode-stage redirect request for a taken branch.
REQ-007: sign_imm  in  32  sign-extended branch offset in words.
REQ-008: out_ready  in  1  decode accepts the IF/ID contents this cycle.
REQ-009: imem_we  in  1  instruction memory write enable.
REQ-010: imem_waddr  in  IDX  word index to write.
REQ-011: imem_wdata  in  32  word to write.
REQ-012: out_valid  out  1  IF/ID holds a valid instruction.
REQ-013: out_instr  out  32  IF/ID instruction word.
REQ-014: out_pc_plus4  out  PC_WIDTH  IF/ID PC+4 of out_instr.
REQ-015: pc  out  PC_WIDTH  current fetch PC.

Function
REQ-016: State SHALL be: pc register, IF/ID register {out_valid, out_instr, out_pc_plus4}, IMEM_DEPTH x 32 memory array.
REQ-017: Fetch word SHALL be imem[pc[IDX+1:2]]; PC bits above IDX+1 are ignored, so addressing wraps modulo IMEM_DEPTH words; pc[1:0] is ignored.
REQ-018: pc+4 SHALL be computed modulo 2^PC_WIDTH.
REQ-019: Branch target SHALL be out_pc_plus4 + (sign_imm << 2), truncated to PC_WIDTH bits, two's-complement (negative offsets move backward).
REQ-020: redirect = pc_src AND out_valid; pc_src with out_valid=0 SHALL be ignored.
REQ-021: advance = (NOT out_valid) OR out_ready.
REQ-022: Per clock edge, priority reset > redirect > advance > hold.
REQ-023: Redirect: pc <= target; out_valid <= 0; out_instr and out_pc_plus4 hold; the branch in IF/ID counts as consumed, the wrong-path word is never presented.
REQ-024: Advance: out_instr <= fetch word; out_pc_plus4 <= pc+4; out_valid <= 1; pc <= pc+4.
REQ-025: Hold (out_valid=1, out_ready=0, no redirect): pc and the IF/ID register SHALL be unchanged.
REQ-026: Fetch latency: a word at PC p appears on out_instr exactly one edge after the edge at which pc=p and advance=1; redirect-to-valid latency is two edges (one bubble).
REQ-027: Memory write: on an edge with imem_we=1, imem[imem_waddr] <= imem_wdata, independent of reset and fetch.
REQ-028: Write and fetch to the same word on the same edge SHALL capture the old word into IF/ID; the new word is visible from the next fetch.
REQ-029: Sustained throughput with out_ready=1 and no redirects SHALL be one instruction per cycle.
REQ-030: Memory contents are undefined at power-up and SHALL NOT be cleared by reset.

Reset
REQ-031: With reset=1 at an edge: pc <= RESET_PC, out_valid <= 0, out_instr <= 0, out_pc_plus4 <= 0, overriding any simultaneous redirect, advance or stall.
REQ-032: First edge after reset deasserts SHALL perform an advance (out_valid=0), fetching imem[RESET_PC index].
REQ-033: Reset mid-stall or mid-redirect SHALL discard all in-flight state; no instruction from before reset is presented afterwards.

Verification
REQ-034: Default params, imem[0..3]=A,B,C,D, reset 1 cycle, out_ready=1 -> successive edges give (A,4),(B,8),(C,12) on out_instr/out_pc_plus4, out_valid=1, pc=4,8,12 then 16.
REQ-035: IF/ID=(B,8), pc=8, out_ready=0 for 3 cycles -> out_instr=B, out_pc_plus4=8, pc=8 held; out_ready=1 -> (C,12) next edge.
REQ-036: IF/ID out_pc_plus4=8 valid, pc_src=1, sign_imm=3 -> pc=20, out_valid=0 next edge; following edge out_instr=imem[5], out_pc_plus4=24.
REQ-037: out_pc_plus4=16 valid, pc_src=1, sign_imm=0xFFFFFFFE -> pc=8; pc_src=1 with out_valid=0 -> no redirect, normal advance.
REQ-038: PC_WIDTH=8, RESET_PC=0xFC, IMEM_DEPTH=64 -> first word imem[63], out_pc_plus4=0x00, pc=0x00; next word imem[0].
REQ-039: imem_we=1, imem_waddr=2, imem_wdata=E on the edge fetching pc=8 (old word C) -> out_instr=C; after redirect back to 8, out_instr=E; reset asserted during a stall -> out_valid=0, pc=RESET_PC, memory retains E.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, word-addressed instruction memory and
// an IF/ID register with valid/ready handshake and decode-stage branch redirect.
module fetch_stage #(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter int unsigned         IMEM_DEPTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pc_src,
    input  logic [31:0]                   sign_imm,
    input  logic                          out_ready,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic                          out_valid,
    output logic [31:0]                   out_instr,
    output logic [PC_WIDTH-1:0]           out_pc_plus4,
    output logic [PC_WIDTH-1:0]           pc
);

    localparam int unsigned IDX = $clog2(IMEM_DEPTH);

    logic [31:0]         imem [IMEM_DEPTH];
    logic [IDX-1:0]      fetch_idx;
    logic [31:0]         fetch_word;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] branch_offset;
    logic [PC_WIDTH-1:0] branch_target;
    logic                redirect;
    logic                advance;

    // Word index only: byte offset and PC bits above the array size are dropped,
    // so fetch addresses wrap around the memory.
    assign fetch_idx  = pc[IDX+1:2];
    assign fetch_word = imem[fetch_idx];
    assign pc_plus4   = pc + PC_WIDTH'(4);

    // Word offset scaled to bytes, sign-extended or truncated to the PC width.
    assign branch_offset = PC_WIDTH'($signed({sign_imm, 2'b00}));
    assign branch_target = out_pc_plus4 + branch_offset;

    assign redirect = pc_src && out_valid;
    assign advance  = !out_valid || out_ready;

    // Memory is never reset; a same-edge fetch sees the old word.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_pc_plus4 <= '0;
        end else if (redirect) begin
            pc        <= branch_target;
            out_valid <= 1'b0;
        end else if (advance) begin
            pc           <= pc_plus4;
            out_valid    <= 1'b1;
            out_instr    <= fetch_word;
            out_pc_plus4 <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// handshake/branch run checked by a program-flow scoreboard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_src;
    logic [31:0] sign_imm;
    logic        out_ready;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;
    logic [31:0] pc;

    logic        reset8;
    logic        out_ready8;
    logic        pc_src8;
    logic [31:0] sign_imm8;
    logic        out_valid8;
    logic [31:0] out_instr8;
    logic [7:0]  out_pc_plus4_8;
    logic [7:0]  pc8;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .pc_src       (pc_src),
        .sign_imm     (sign_imm),
        .out_ready    (out_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc_plus4 (out_pc_plus4),
        .pc           (pc)
    );

    fetch_stage #(
        .PC_WIDTH   (8),
        .IMEM_DEPTH (64),
        .RESET_PC   (8'hFC)
    ) dut8 (
        .clk          (clk),
        .reset        (reset8),
        .pc_src       (pc_src8),
        .sign_imm     (sign_imm8),
        .out_ready    (out_ready8),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .out_valid    (out_valid8),
        .out_instr    (out_instr8),
        .out_pc_plus4 (out_pc_plus4_8),
        .pc           (pc8)
    );

    localparam logic [31:0] W_A = 32'hAAAA_0001;
    localparam logic [31:0] W_B = 32'hBBBB_0002;
    localparam logic [31:0] W_C = 32'hCCCC_0003;
    localparam logic [31:0] W_D = 32'hDDDD_0004;
    localparam logic [31:0] W_E = 32'hEEEE_0005;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] mem [64];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    sb_t         sbq[$];
    logic        sb_on = 1'b0;
    logic        redir_pend = 1'b0;
    logic [31:0] exp_target;
    int unsigned idle_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_if(input string tag, input logic v, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic [31:0] pcv);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".instr"}, out_instr, instr);
        chk({tag, ".pc4"},   out_pc_plus4, pc4);
        chk({tag, ".pc"},    pc, pcv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: entries are the instructions decode should see, in program order.
    always @(negedge clk) begin
        if (sb_on) begin
            sb_t e;
            if (redir_pend) begin
                chk("bubble_valid", 32'(out_valid), 32'd0);
                chk("redirect_pc", pc, exp_target);
                redir_pend = 1'b0;
            end else if (out_valid) begin
                idle_run = 0;
                if (sbq.size() == 0) begin
                    chk("queue_nonempty", 32'd0, 32'd1);
                end else begin
                    e = sbq[0];
                    chk("sb_instr", out_instr, e.instr);
                    chk("sb_pc4", out_pc_plus4, e.pc4);
                    chk("sb_pc", pc, e.pc4);
                    if (pc_src) begin
                        logic [31:0] tgt;
                        tgt = e.pc4 + (sign_imm << 2);
                        void'(sbq.pop_front());
                        sbq.push_back('{instr: mem[tgt[7:2]], pc4: tgt + 32'd4});
                        exp_target = tgt;
                        redir_pend = 1'b1;
                    end else if (out_ready) begin
                        logic [31:0] nxt;
                        nxt = e.pc4;
                        void'(sbq.pop_front());
                        sbq.push_back('{instr: mem[nxt[7:2]], pc4: nxt + 32'd4});
                    end
                end
            end else begin
                idle_run++;
                if (idle_run > 1) begin
                    chk("fetch_timeout", idle_run, 32'd1);
                    idle_run = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        reset8     = 1'b1;
        pc_src     = 1'b0;
        pc_src8    = 1'b0;
        sign_imm   = '0;
        sign_imm8  = '0;
        out_ready  = 1'b0;
        out_ready8 = 1'b0;
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;

        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
        end
        mem[0] = W_A;
        mem[1] = W_B;
        mem[2] = W_C;
        mem[3] = W_D;

        // Preload both memories through the shared write port while in reset.
        for (int i = 0; i < 64; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 6'(i);
            imem_wdata = mem[i];
            tick();
        end
        imem_we = 1'b0;
        expect_if("reset", 1'b0, 32'd0, 32'd0, 32'd0);

        reset     = 1'b0;
        out_ready = 1'b1;
        tick(); expect_if("fetch_A", 1'b1, W_A, 32'd4, 32'd4);
        tick(); expect_if("fetch_B", 1'b1, W_B, 32'd8, 32'd8);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_if("stall", 1'b1, W_B, 32'd8, 32'd8);
        end
        out_ready = 1'b1;
        tick(); expect_if("resume_C", 1'b1, W_C, 32'd12, 32'd12);
        tick(); expect_if("fetch_D", 1'b1, W_D, 32'd16, 32'd16);

        pc_src   = 1'b1;
        sign_imm = 32'hFFFF_FFFE;
        tick(); expect_if("redir_back", 1'b0, W_D, 32'd16, 32'd8);
        tick(); expect_if("src_ignored", 1'b1, W_C, 32'd12, 32'd12);
        sign_imm = 32'hFFFF_FFFD;
        tick(); expect_if("redir_zero", 1'b0, W_C, 32'd12, 32'd0);
        pc_src = 1'b0;
        tick(); expect_if("refetch_A", 1'b1, W_A, 32'd4, 32'd4);
        tick(); expect_if("refetch_B", 1'b1, W_B, 32'd8, 32'd8);

        pc_src   = 1'b1;
        sign_imm = 32'd3;
        tick(); expect_if("redir_fwd", 1'b0, W_B, 32'd8, 32'd20);
        pc_src = 1'b0;
        tick(); expect_if("after_bubble", 1'b1, mem[5], 32'd24, 32'd24);

        pc_src   = 1'b1;
        sign_imm = 32'hFFFF_FFFC;
        tick(); expect_if("redir_to8", 1'b0, mem[5], 32'd24, 32'd8);
        pc_src     = 1'b0;
        imem_we    = 1'b1;
        imem_waddr = 6'd2;
        imem_wdata = W_E;
        tick(); expect_if("wr_same_edge", 1'b1, W_C, 32'd12, 32'd12);
        imem_we  = 1'b0;
        mem[2]   = W_E;
        pc_src   = 1'b1;
        sign_imm = 32'hFFFF_FFFF;
        tick(); expect_if("redir_again", 1'b0, W_C, 32'd12, 32'd8);
        pc_src = 1'b0;
        tick(); expect_if("new_word", 1'b1, W_E, 32'd12, 32'd12);

        out_ready = 1'b0;
        tick(); expect_if("hold_E", 1'b1, W_E, 32'd12, 32'd12);
        reset = 1'b1;
        tick(); expect_if("reset_stall", 1'b0, 32'd0, 32'd0, 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick(); expect_if("post_rst_A", 1'b1, W_A, 32'd4, 32'd4);
        tick(); expect_if("post_rst_B", 1'b1, W_B, 32'd8, 32'd8);
        tick(); expect_if("mem_kept", 1'b1, W_E, 32'd12, 32'd12);

        // Narrow PC: reset PC 0xFC wraps to word 63, then to word 0.
        reset8     = 1'b0;
        out_ready8 = 1'b1;
        tick();
        chk("pc8_valid0", 32'(out_valid8), 32'd1);
        chk("pc8_instr0", out_instr8, mem[63]);
        chk("pc8_pc4_0", 32'(out_pc_plus4_8), 32'h00);
        chk("pc8_pc0", 32'(pc8), 32'h00);
        tick();
        chk("pc8_instr1", out_instr8, mem[0]);
        chk("pc8_pc4_1", 32'(out_pc_plus4_8), 32'h04);
        chk("pc8_pc1", 32'(pc8), 32'h04);

        // Randomized handshake and branch traffic from a fresh reset.
        reset = 1'b1;
        tick();
        sbq.delete();
        sbq.push_back('{instr: mem[0], pc4: 32'd4});
        redir_pend = 1'b0;
        idle_run   = 0;
        reset      = 1'b0;
        sb_on      = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            int off;
            off       = int'($urandom_range(32)) - 16;
            out_ready = ($urandom_range(9) < 7);
            pc_src    = ($urandom_range(9) < 2);
            sign_imm  = 32'(off);
            tick();
        end
        sb_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
